// File: rtl/matrix_keypad_scanner_if.sv
// Key delivery bus between the keypad scanner (master) and user logic (slave).
// key_code/key_valid/key_ready form a valid/ready handshake.
// key_down and key_overrun are status lines that travel alongside it.
interface matrix_keypad_scanner_if #(
   parameter int CODE_W = 4
);
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_ready;
   logic              key_down;
   logic              key_overrun;

   modport master (
      output key_code,
      output key_valid,
      input  key_ready,
      output key_down,
      output key_overrun
   );

   modport slave (
      input  key_code,
      input  key_valid,
      output key_ready,
      input  key_down,
      input  key_overrun
   );
endinterface

// File: rtl/matrix_keypad_scanner.sv
// Row/column keypad scanner.
// Strobes one active-low column at a time and reads the active-low rows back.
// Each full scan is reduced to a NONE / SINGLE(code) / MULTI result.
// Presses and releases are debounced over whole scans.
// Each accepted press is delivered once through a one-entry valid/ready buffer.
module matrix_keypad_scanner #(
   parameter int NUM_ROWS       = 4,
   parameter int NUM_COLS       = 4,
   parameter int COL_CYCLES     = 125000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                clk,
   input  logic                rst,
   output logic [NUM_COLS-1:0] col_out,
   input  logic [NUM_ROWS-1:0] row_in,
   matrix_keypad_scanner_if.master key_bus
);

   localparam int CODE_W  = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1;
   localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int DWELL_W = $clog2(COL_CYCLES);
   localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(COL_CYCLES - 1);
   localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NUM_COLS - 1);
   localparam logic [CNT_W-1:0]   DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_CHK,
      HELD,
      RELEASE_CHK
   } state_t;

   logic [NUM_ROWS-1:0] row_meta;
   logic [NUM_ROWS-1:0] row_sync;
   logic [DWELL_W-1:0]  dwell;
   logic [COL_W-1:0]    col_idx;
   logic                sample;
   logic                scan_done;

   logic                col_any;
   logic                col_multi;
   logic [CODE_W-1:0]   col_code;

   logic                acc_hit;
   logic                acc_multi;
   logic [CODE_W-1:0]   acc_code;
   logic                scan_hit;
   logic                scan_multi;
   logic [CODE_W-1:0]   scan_code;
   logic                res_single;
   logic                res_none;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
   logic [CODE_W-1:0]   cand, cand_n;
   logic                accept;
   logic [CODE_W-1:0]   accept_code;

   logic                key_down_q;
   logic                key_valid_q;
   logic [CODE_W-1:0]   key_code_q;
   logic                key_overrun_q;

   // Two-flop synchroniser for the asynchronous row pins; idles high like the pull-ups.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta <= '1;
         row_sync <= '1;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

   // Column dwell timer and column index; each column is held low for COL_CYCLES clocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell   <= '0;
         col_idx <= '0;
      end else if (dwell == LAST_DWELL) begin
         dwell   <= '0;
         col_idx <= (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;
      end else begin
         dwell <= dwell + 1'b1;
      end
   end

   assign sample    = (dwell == LAST_DWELL);
   assign scan_done = sample && (col_idx == LAST_COL);

   // Drive exactly one column strobe low.
   always_comb begin
      col_out          = '1;
      col_out[col_idx] = 1'b0;
   end

   // Look at the settled rows of the strobed column: first low row wins, more than one is a chord.
   always_comb begin
      col_any   = 1'b0;
      col_multi = 1'b0;
      col_code  = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (!row_sync[r]) begin
            if (col_any) begin
               col_multi = 1'b1;
            end else begin
               col_code = CODE_W'(r * NUM_COLS) + CODE_W'(col_idx);
            end
            col_any = 1'b1;
         end
      end
   end

   // Merge this column into the running scan; any second hit in the scan makes it MULTI.
   always_comb begin
      scan_hit   = acc_hit | col_any;
      scan_multi = acc_multi | col_multi | (acc_hit & col_any);
      scan_code  = acc_hit ? acc_code : col_code;
      res_single = scan_done && scan_hit && !scan_multi;
      res_none   = scan_done && !scan_hit;
   end

   // Scan accumulator: updated on each column sample, cleared once the scan result is produced.
   always_ff @(posedge clk) begin
      if (rst || scan_done) begin
         acc_hit   <= 1'b0;
         acc_multi <= 1'b0;
         acc_code  <= '0;
      end else if (sample) begin
         acc_hit   <= scan_hit;
         acc_multi <= scan_multi;
         acc_code  <= scan_code;
      end
   end

   // Debounce state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cand  <= cand_n;
      end
   end

   assign cnt_inc = cnt + 1'b1;

   // Debounce next-state logic; it only moves when a full scan result arrives.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cand_n      = cand;
      accept      = 1'b0;
      accept_code = cand;
      if (scan_done) begin
         unique case (state)
            IDLE: begin
               if (res_single) begin
                  cand_n = scan_code;
                  cnt_n  = CNT_W'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     accept      = 1'b1;
                     accept_code = scan_code;
                     state_n     = HELD;
                  end else begin
                     state_n = PRESS_CHK;
                  end
               end else begin
                  cnt_n = '0;
               end
            end
            PRESS_CHK: begin
               if (res_single) begin
                  if (scan_code == cand) begin
                     cnt_n = cnt_inc;
                     if (cnt_inc == DEB_TARGET) begin
                        accept  = 1'b1;
                        state_n = HELD;
                     end
                  end else begin
                     cand_n = scan_code;
                     cnt_n  = CNT_W'(1);
                  end
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end
            HELD: begin
               if (res_none) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_n = IDLE;
                     cnt_n   = '0;
                  end else begin
                     state_n = RELEASE_CHK;
                     cnt_n   = CNT_W'(1);
                  end
               end
            end
            RELEASE_CHK: begin
               if (res_none) begin
                  cnt_n = cnt_inc;
                  if (cnt_inc == DEB_TARGET) begin
                     state_n = IDLE;
                     cnt_n   = '0;
                  end
               end else begin
                  state_n = HELD;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // Registered held-key level, following the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_down_q <= 1'b0;
      end else begin
         key_down_q <= (state_n == HELD) || (state_n == RELEASE_CHK);
      end
   end

   // One-entry output buffer; a press accepted while the buffer is full is dropped and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_valid_q   <= 1'b0;
         key_code_q    <= '0;
         key_overrun_q <= 1'b0;
      end else begin
         key_overrun_q <= 1'b0;
         if (accept) begin
            if (!key_valid_q || key_bus.key_ready) begin
               key_code_q  <= accept_code;
               key_valid_q <= 1'b1;
            end else begin
               key_overrun_q <= 1'b1;
            end
         end else if (key_valid_q && key_bus.key_ready) begin
            key_valid_q <= 1'b0;
         end
      end
   end

   assign key_bus.key_code    = key_code_q;
   assign key_bus.key_valid   = key_valid_q;
   assign key_bus.key_down    = key_down_q;
   assign key_bus.key_overrun = key_overrun_q;

endmodule
